// File: rtl/preproc_pkg.sv
// Shared types and defaults for the preprocessing stream stages.
// State encoding is fixed so that observers outside the scheduler can decode it.
package preproc_pkg;

    localparam int unsigned IN_W_DEF   = 12;
    localparam int unsigned OUT_W_DEF  = 32;
    localparam int unsigned CB_LEN_DEF = 8;
    localparam int unsigned CR_LEN_DEF = 8;
    localparam int unsigned Y_LEN_DEF  = 48;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CB   = 2'd1,
        S_CR   = 2'd2,
        S_Y    = 2'd3
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [OUT_W_DEF-1:0] sign_ext(input logic [IN_W_DEF-1:0] d);
        return {{(OUT_W_DEF - IN_W_DEF){d[IN_W_DEF-1]}}, d};
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage AXI-Stream output register; holds its word while the sink stalls.
module axis_out_reg #(
    parameter int unsigned W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         load_i,
    input  logic [W-1:0] din_i,
    input  logic         last_i,
    input  logic         tready_i,
    output logic [W-1:0] tdata_o,
    output logic         tvalid_o,
    output logic         tlast_o,
    output logic         free_o
);

    logic [W-1:0] tdata_q;
    logic         tvalid_q;
    logic         tlast_q;

    assign free_o = !tvalid_q || tready_i;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else if (load_i) begin
            tdata_q  <= din_i;
            tvalid_q <= 1'b1;
            tlast_q  <= last_i;
        end else if (tready_i) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end
    end

    assign tdata_o  = tdata_q;
    assign tvalid_o = tvalid_q;
    assign tlast_o  = tlast_q;

endmodule

// File: rtl/axis_frame_scheduler.sv
// Merges Cb, Cr and Y producers into one AXI-Stream frame in fixed section order,
// sign-extending samples and marking the final Y word with tlast.
module axis_frame_scheduler
    import preproc_pkg::*;
#(
    parameter int unsigned IN_W   = IN_W_DEF,
    parameter int unsigned OUT_W  = OUT_W_DEF,
    parameter int unsigned CB_LEN = CB_LEN_DEF,
    parameter int unsigned CR_LEN = CR_LEN_DEF,
    parameter int unsigned Y_LEN  = Y_LEN_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [IN_W-1:0]  s_cb_data,
    input  logic             s_cb_valid,
    output logic             s_cb_ready,
    input  logic [IN_W-1:0]  s_cr_data,
    input  logic             s_cr_valid,
    output logic             s_cr_ready,
    input  logic [IN_W-1:0]  s_y_data,
    input  logic             s_y_valid,
    output logic             s_y_ready,
    output logic [OUT_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic             o_busy,
    output logic [15:0]      o_frame_cnt
);

    localparam int unsigned CNT_W = $clog2(max3(CB_LEN, CR_LEN, Y_LEN) + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    logic             out_free;
    logic             sel_valid;
    logic [IN_W-1:0]  sel_data;
    logic [CNT_W-1:0] sec_max;
    logic             sec_last;
    logic             accept;
    logic [OUT_W-1:0] sel_ext;

    assign s_cb_ready = (state_q == S_CB) && out_free;
    assign s_cr_ready = (state_q == S_CR) && out_free;
    assign s_y_ready  = (state_q == S_Y)  && out_free;

    // Only the granted producer's data reaches the output mux.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sec_max   = '0;
        unique case (state_q)
            S_CB: begin
                sel_valid = s_cb_valid;
                sel_data  = s_cb_data;
                sec_max   = CNT_W'(CB_LEN - 1);
            end
            S_CR: begin
                sel_valid = s_cr_valid;
                sel_data  = s_cr_data;
                sec_max   = CNT_W'(CR_LEN - 1);
            end
            S_Y: begin
                sel_valid = s_y_valid;
                sel_data  = s_y_data;
                sec_max   = CNT_W'(Y_LEN - 1);
            end
            default: ;
        endcase
    end

    assign sec_last = (cnt_q == sec_max);
    assign accept   = sel_valid && out_free;
    assign sel_ext  = {{(OUT_W - IN_W){sel_data[IN_W-1]}}, sel_data};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
            if (i_en) state_d = S_CB;
        end else if (accept) begin
            if (sec_last) begin
                cnt_d = '0;
                unique case (state_q)
                    S_CB:    state_d = S_CR;
                    S_CR:    state_d = S_Y;
                    default: state_d = i_en ? S_CB : S_IDLE;
                endcase
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign frame_cnt_d = frame_cnt_q + 16'(m_axis_tvalid && m_axis_tready && m_axis_tlast);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    axis_out_reg #(
        .W (OUT_W)
    ) u_out (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .load_i   (accept),
        .din_i    (sel_ext),
        .last_i   ((state_q == S_Y) && sec_last),
        .tready_i (m_axis_tready),
        .tdata_o  (m_axis_tdata),
        .tvalid_o (m_axis_tvalid),
        .tlast_o  (m_axis_tlast),
        .free_o   (out_free)
    );

    assign o_busy      = (state_q != S_IDLE);
    assign o_frame_cnt = frame_cnt_q;

endmodule
